// File: rtl/pipelined_cla_adder_if.sv
// Handshake/operand bundle for pipelined_cla_adder.
// master = operand producer / result consumer, slave = the adder.
interface pipelined_cla_adder_if #(
  parameter int NBIT = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [NBIT-1:0] a;
  logic [NBIT-1:0] b;
  logic            cin;
  logic            sub;
  logic            out_valid;
  logic            out_ready;
  logic [NBIT-1:0] s;
  logic            cout;
  logic            ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead add/subtract.
// The NBIT operation is cut into STAGES chunks of CW bits; each chunk is a
// two-level lookahead adder (bit level inside BLOCK-bit groups, group level
// across the chunk). The carry out of a chunk is registered and handed to
// the next stage. Operand bits not yet consumed travel in a right-shifting
// register (next chunk always sits at bit 0); finished result chunks enter
// at the top of a right-shifting result register, so after the last stage
// chunk 0 has arrived at bit 0 and the word leaves aligned.
// One global advance enable freezes the whole pipe under backpressure.
module pipelined_cla_adder #(
  parameter int NBIT   = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  pipelined_cla_adder_if.slave bus
);

  localparam int CW   = NBIT / STAGES;
  localparam int NBLK = CW / BLOCK;

  // One chunk: returns {carry out of MSB, carry into MSB, sum}.
  // Every carry is a flat sum of products of g/p terms, so there is no
  // bit-to-bit ripple inside a block nor block-to-block ripple in a chunk.
  function automatic logic [CW+1:0] chunk_add(
    input logic [CW-1:0] x,
    input logic [CW-1:0] y,
    input logic          ci
  );
    logic [CW-1:0]   g;
    logic [CW-1:0]   p;
    logic [NBLK-1:0] bg;
    logic [NBLK-1:0] bp;
    logic [NBLK:0]   bc;
    logic [CW:0]     c;
    logic            term;
    g = x & y;
    p = x ^ y;
    // group generate / propagate
    for (int m = 0; m < NBLK; m++) begin
      bp[m] = 1'b1;
      bg[m] = 1'b0;
      for (int i = 0; i < BLOCK; i++) begin
        bp[m] = bp[m] & p[m*BLOCK+i];
        term  = g[m*BLOCK+i];
        for (int j = i + 1; j < BLOCK; j++) begin
          term = term & p[m*BLOCK+j];
        end
        bg[m] = bg[m] | term;
      end
    end
    // carry into each group, expanded from the chunk carry-in
    for (int m = 0; m <= NBLK; m++) begin
      term = ci;
      for (int j = 0; j < m; j++) begin
        term = term & bp[j];
      end
      bc[m] = term;
      for (int k = 0; k < m; k++) begin
        term = bg[k];
        for (int j = k + 1; j < m; j++) begin
          term = term & bp[j];
        end
        bc[m] = bc[m] | term;
      end
    end
    // carry into each bit, expanded from its group carry-in
    for (int m = 0; m < NBLK; m++) begin
      for (int i = 0; i < BLOCK; i++) begin
        term = bc[m];
        for (int j = 0; j < i; j++) begin
          term = term & p[m*BLOCK+j];
        end
        c[m*BLOCK+i] = term;
        for (int k = 0; k < i; k++) begin
          term = g[m*BLOCK+k];
          for (int j = k + 1; j < i; j++) begin
            term = term & p[m*BLOCK+j];
          end
          c[m*BLOCK+i] = c[m*BLOCK+i] | term;
        end
      end
    end
    c[CW] = bc[NBLK];
    return {c[CW], c[CW-1], p ^ c[CW-1:0]};
  endfunction

  logic [NBIT-1:0]   a_reg [STAGES];
  logic [NBIT-1:0]   b_reg [STAGES];
  logic [NBIT-1:0]   s_reg [STAGES];
  logic [STAGES-1:0] valid_reg;
  logic [STAGES-1:0] carry_reg;
  logic              ovf_reg;

  logic [NBIT-1:0]   a_next [STAGES];
  logic [NBIT-1:0]   b_next [STAGES];
  logic [NBIT-1:0]   s_next [STAGES];
  logic [STAGES-1:0] valid_next;
  logic [STAGES-1:0] carry_next;
  logic              ovf_next;
  logic              adv;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [NBIT-1:0] x_src;
      logic [NBIT-1:0] y_src;
      logic            c_src;
      logic [CW+1:0]   res;

      if (gi == 0) begin : g_head
        // operand transform at accept: subtract is a + ~b + 1
        assign x_src         = bus.a;
        assign y_src         = bus.sub ? ~bus.b : bus.b;
        assign c_src         = bus.sub | bus.cin;
        assign valid_next[gi] = bus.in_valid;
        assign s_next[gi]    = NBIT'(res[CW-1:0]) << (NBIT - CW);
      end else begin : g_body
        assign x_src         = a_reg[gi-1];
        assign y_src         = b_reg[gi-1];
        assign c_src         = carry_reg[gi-1];
        assign valid_next[gi] = valid_reg[gi-1];
        assign s_next[gi]    = (s_reg[gi-1] >> CW) | (NBIT'(res[CW-1:0]) << (NBIT - CW));
      end

      assign res            = chunk_add(x_src[CW-1:0], y_src[CW-1:0], c_src);
      assign a_next[gi]     = x_src >> CW;
      assign b_next[gi]     = y_src >> CW;
      assign carry_next[gi] = res[CW+1];

      if (gi == STAGES - 1) begin : g_tail
        // signed overflow: carry into MSB differs from carry out of MSB
        assign ovf_next = res[CW+1] ^ res[CW];
      end
    end
  endgenerate

  assign adv           = !valid_reg[STAGES-1] || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = valid_reg[STAGES-1];
  assign bus.s         = s_reg[STAGES-1];
  assign bus.cout      = carry_reg[STAGES-1];
  assign bus.ovf       = ovf_reg;

  // Advance every stage together; data loads only with a valid token so
  // bubbles leave the last result visible on s/cout/ovf.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_reg[k] <= '0;
        b_reg[k] <= '0;
        s_reg[k] <= '0;
      end
      valid_reg <= '0;
      carry_reg <= '0;
      ovf_reg   <= 1'b0;
    end else if (adv) begin
      valid_reg <= valid_next;
      for (int k = 0; k < STAGES; k++) begin
        if (valid_next[k]) begin
          a_reg[k]     <= a_next[k];
          b_reg[k]     <= b_next[k];
          s_reg[k]     <= s_next[k];
          carry_reg[k] <= carry_next[k];
        end
      end
      if (valid_next[STAGES-1]) begin
        ovf_reg <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: three configurations (32/4/4, 16/4/1,
// 64/4/8) share one stimulus stream; each has its own arithmetic model
// scoreboard and per-cycle monitor.
module tb_pipelined_cla_adder;

  typedef struct {
    logic [65:0] exp;
    logic [65:0] lit;
    bit          has_lit;
    int          acc;
    bit          lat;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] a_drv;
  logic [63:0] b_drv;
  logic        cin_drv;
  logic        sub_drv;
  int          lit_cfg;
  logic [65:0] lit_val;
  bit          lat_ok;
  bit          thru;
  int          cyc;
  int          checks;
  int          failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int cfg, input logic [66:0] act, input logic [66:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cfg%0d actual=%h required=%h (cycle %0d)", name, cfg, act, exp, cyc);
    end
  endtask

  // {ovf, cout, s} from plain arithmetic on a w-bit word
  function automatic logic [65:0] model(input int w, input logic [63:0] ai, input logic [63:0] bi,
                                        input logic ci, input logic si);
    logic [63:0] m;
    logic [63:0] ma;
    logic [63:0] mb;
    logic [63:0] rs;
    logic [65:0] wide;
    logic        co;
    logic        ov;
    logic        sa;
    logic        sb;
    logic        ss;
    m  = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    ma = ai & m;
    mb = bi & m;
    if (si) begin
      rs = (ma - mb) & m;
      co = (ma >= mb);
    end else begin
      wide = {2'b00, ma} + {2'b00, mb} + 66'(ci);
      rs   = wide[63:0] & m;
      co   = wide[w];
    end
    sa = ma[w-1];
    sb = mb[w-1];
    ss = rs[w-1];
    ov = si ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
    return {ov, co, rs};
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int NB = (gi == 0) ? 32 : (gi == 1) ? 16 : 64;
    localparam int ST = (gi == 0) ? 4 : (gi == 1) ? 1 : 8;

    pipelined_cla_adder_if #(.NBIT(NB)) bus ();

    pipelined_cla_adder #(.NBIT(NB), .BLOCK(4), .STAGES(ST)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    assign bus.in_valid  = in_valid;
    assign bus.a         = a_drv[NB-1:0];
    assign bus.b         = b_drv[NB-1:0];
    assign bus.cin       = cin_drv;
    assign bus.sub       = sub_drv;
    assign bus.out_ready = out_ready;

    ent_t        sb[$];
    bit          stall_prev;
    bit          ov_prev;
    logic [65:0] held;

    // Per-cycle monitor: sampled mid-cycle, sees what the next edge will transfer.
    always @(negedge clk) begin
      ent_t        e;
      logic [65:0] act;
      act = {bus.ovf, bus.cout, 64'(bus.s)};
      if (!rst_n) begin
        sb.delete();
        stall_prev = 1'b0;
        ov_prev    = 1'b0;
        chk("reset_outputs", gi, {bus.out_valid, act}, 67'd0);
        chk("reset_in_ready", gi, 67'(bus.in_ready), 67'd1);
      end else begin
        if (stall_prev) begin
          chk("stall_valid_held", gi, 67'(bus.out_valid), 67'd1);
          chk("stall_result_held", gi, 67'(act), 67'(held));
        end
        if (bus.out_valid && !bus.out_ready)
          chk("in_ready_stalled", gi, 67'(bus.in_ready), 67'd0);
        else
          chk("in_ready_free", gi, 67'(bus.in_ready), 67'd1);
        if (sb.size() == 0) begin
          chk("idle_out_valid", gi, 67'(bus.out_valid), 67'd0);
        end else begin
          if (thru && ov_prev)
            chk("full_rate_continuous", gi, 67'(bus.out_valid), 67'd1);
          if (bus.out_valid && bus.out_ready) begin
            e = sb.pop_front();
            $display("cfg%0d out s=%h cout=%b ovf=%b", gi, bus.s, bus.cout, bus.ovf);
            chk("result_vs_model", gi, 67'(act), 67'(e.exp));
            if (e.has_lit) chk("result_vs_literal", gi, 67'(act), 67'(e.lit));
            if (e.lat) chk("latency", gi, 67'(cyc - e.acc), 67'(ST - 1));
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          e.exp     = model(NB, a_drv, b_drv, cin_drv, sub_drv);
          e.has_lit = (lit_cfg == gi) || (lit_cfg == 3);
          e.lit     = lit_val;
          e.acc     = cyc + 1;
          e.lat     = lat_ok;
          if (e.has_lit) chk("model_pin", gi, 67'(e.exp), 67'(lit_val));
          sb.push_back(e);
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        held       = act;
        ov_prev    = bus.out_valid;
      end
    end
  end

  task automatic send(input logic [63:0] av, input logic [63:0] bv, input logic cv, input logic sv,
                      input int lc, input logic [65:0] lv);
    in_valid = 1'b1;
    a_drv    = av;
    b_drv    = bv;
    cin_drv  = cv;
    sub_drv  = sv;
    lit_cfg  = lc;
    lit_val  = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    lit_cfg  = -1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_drv     = '0;
    b_drv     = '0;
    cin_drv   = 1'b0;
    sub_drv   = 1'b0;
    lit_cfg   = -1;
    lit_val   = '0;
    lat_ok    = 1'b0;
    thru      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // directed corners with hand-computed {ovf,cout,s}
    lat_ok = 1'b1;
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0, 66'h1_0000000000000000);
    send(64'h0000_0000_8000_0000, 64'h1, 1'b0, 1'b1, 0, 66'h3_000000007FFFFFFF);
    send(64'h3,                   64'h5, 1'b1, 1'b1, 0, 66'h0_00000000FFFFFFFE);
    send(64'h7FFF_FFFF_FFFF_7FFF, 64'h1, 1'b0, 1'b0, 1, 66'h2_0000000000008000);
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 2, 66'h2_8000000000000000);
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 2, 66'h3_0000000000000000);
    send(64'hFFFF,                64'hFFFF, 1'b1, 1'b0, 1, 66'h1_000000000000FFFF);
    idle(12);

    // full throughput: a=i, b=i, cin=1 -> s=2i+1
    thru = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(64'(i), 64'(i), 1'b1, 1'b0, 3, 66'(2 * i + 1));
    end
    idle(12);
    thru   = 1'b0;
    lat_ok = 1'b0;

    // random operands under random backpressure
    for (int i = 0; i < 48; i++) begin
      out_ready = ($urandom_range(0, 2) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      a_drv     = {$urandom, $urandom};
      b_drv     = {$urandom, $urandom};
      cin_drv   = $urandom_range(0, 1) != 0;
      sub_drv   = $urandom_range(0, 1) != 0;
      lit_cfg   = -1;
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    idle(20);

    // reset with operations still in flight
    send(64'h1111, 64'h2222, 1'b0, 1'b0, -1, '0);
    send(64'h3333, 64'h4444, 1'b1, 1'b0, -1, '0);
    send(64'h5555, 64'h6666, 1'b0, 1'b1, -1, '0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(15);

    // a transaction after reset still flows
    lat_ok = 1'b1;
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0, 66'h1_0000000000000000);
    idle(12);
    lat_ok = 1'b0;

    chk("drain_empty", 0, 67'(g_cfg[0].sb.size()), 67'd0);
    chk("drain_empty", 1, 67'(g_cfg[1].sb.size()), 67'd0);
    chk("drain_empty", 2, 67'(g_cfg[2].sb.size()), 67'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_cla_adder.md
# pipelined_cla_adder

Parametrised, pipelined successor to the team's combinational carry-lookahead adder. Splits an NBIT add/subtract into STAGES register-separated chunks, each built from BLOCK-bit lookahead blocks, with the carry handed stage to stage. Adds a valid/ready handshake with backpressure and signed-overflow detection. Sits in the datapath wherever a 32-bit-class adder would otherwise limit the cycle time.

## Interface
- NBIT, 32: operand width; must be a multiple of STAGES*BLOCK
- BLOCK, 4: width of one lookahead block (generate/propagate group)
- STAGES, 4: pipeline depth, 1..NBIT/BLOCK; chunk width CW = NBIT/STAGES
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  operand transfer request
- in_ready  output  1  block can accept operands this cycle
- a  input  NBIT  operand A (unsigned or two's complement)
- b  input  NBIT  operand B
- cin  input  1  carry in (add mode only)
- sub  input  1  0: s = a + b + cin; 1: s = a - b (cin ignored)
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result
- s  output  NBIT  sum/difference, registered
- cout  output  1  carry out of bit NBIT-1 (in sub mode: 1 = no borrow)
- ovf  output  1  signed overflow of the operation performed

## Operation
- Input transform at accept: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
- Stage k (0..STAGES-1) adds bits [k*CW +: CW] of a and b_eff with carry from stage k-1 (stage 0: c0), using CW/BLOCK lookahead blocks with block-level carry lookahead inside the chunk; no ripple between bits inside a block.
- Skew: operand bits for chunks > k ride in pipeline registers until their stage; deskew: result bits of chunks < k ride forward, so all NBIT result bits leave the final stage together.
- Per-stage valid bit travels with the data; no data is dropped or duplicated.
- ovf = carry into MSB XOR carry out of MSB, computed in the last stage.
- cout = carry out of MSB; sub mode reports raw carry (a >= b unsigned gives cout=1).
- Global enable: adv = !out_valid || out_ready. When adv=1 every stage register loads from its predecessor (stage 0 loads accepted operands, or a bubble if in_valid=0). When adv=0 all stage registers hold.
- in_ready = adv (combinational from out_valid/out_ready). Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Bubbles are not compressed while stalled; this is intended (no per-stage skid logic).

## Timing
- Reset (rst_n low, async): all valid bits 0, out_valid=0, s=0, cout=0, ovf=0, all pipeline data registers 0. in_ready=1 immediately while out_valid=0.
- Release of rst_n takes effect on the next rising edge; no transfer is accepted on a clock edge during which rst_n is low.
- Latency: operands accepted at edge N appear with out_valid=1 after edge N+STAGES-1... i.e. out_valid rises after STAGES accepting edges with adv=1 continuous (STAGES=1: result visible the cycle after accept).
- Throughput: one result per cycle while in_valid=1 and out_ready=1.
- Stall: out_valid=1, out_ready=0 → s/cout/ovf/out_valid held stable, in_ready=0, all inner stages frozen; operands presented meanwhile are not taken.
- Simultaneous out transfer and in transfer in the same cycle is legal and required at full rate.
- Reset mid-operation: all in-flight results discarded; no out_valid pulse after rst_n release until new operands traverse the pipe.
- Outputs s/cout/ovf are undefined-free: they hold the last result (or 0 after reset) when out_valid=0.

## Test plan
- Reset: rst_n=0 mid-stream with 3 ops in flight → out_valid=0, s=0, cout=0, ovf=0 asynchronously; no stale result after release.
- Latency/add (defaults): a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 accepted at edge N → after 4 edges s=0x00000000, cout=1, ovf=0; full-chain carry across all stages.
- Subtract/overflow: a=0x80000000, b=0x00000001, sub=1 → s=0x7FFFFFFF, cout=1, ovf=1; a=3, b=5, sub=1 → s=0xFFFFFFFE, cout=0, ovf=0.
- Backpressure: stream 16 random ops, toggle out_ready pseudo-randomly → results match a+b+cin (33-bit compare {cout,s}) in order, none lost/duplicated, s stable while stalled.
- Full throughput: in_valid=1, out_ready=1 for 16 cycles with a=i, b=i, cin=1 → out_valid continuous after fill, s=2i+1 each cycle.
- Parameter sweep: NBIT=16/BLOCK=4/STAGES=1 and NBIT=64/BLOCK=4/STAGES=8 with 0x7FFF+0x0001 style corner cases → correct s/cout/ovf, latency equals STAGES.
